avl_bus_router: RTL
===================

Name: avl_bus_router

Overview:
- Parametrised 1-master to N-slave Avalon-MM router and successor of the fixed address-map demo tables.
- Decodes each master command against a per-slave {field length, address block} map and forwards the command to the matching slave.
- Locks selection for write bursts, tracks outstanding read beats so read data returns in order, and answers unmapped addresses from an internal error responder.
- Sits between the CPU/bus master and the peripheral/memory slaves.

Parameters:
- SLAVE_NUM, 8, number of slave ports (1..32).
- ADDR_MAP_TAB_FIELD_LEN, int[0:31], per-slave count of upper address bits compared (0 disables the entry).
- ADDR_MAP_TAB_ADDR_BLOCK, int[0:31], per-slave base address; only the upper FIELD_LEN bits are used.
- MAX_RD_BEATS, 64, maximum outstanding read beats (counter ceiling).
- ERR_RD_DATA, 32'h0000_0000, data returned for reads to unmapped addresses.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- m_address  in  32  master address
- m_byte_en  in  4  byte enables
- m_read / m_write  in  1  command strobes
- m_write_data  in  32  write data
- m_begin_burst_transfer  in  1  first beat of a burst
- m_burst_count  in  8  burst length in beats (0 is treated as 1)
- m_wait_request  out  1  master stall
- m_read_data  out  32  returned read data
- m_read_data_valid  out  1  read beat valid
- s_address  out  SLAVE_NUM×32  per-slave address
- s_byte_en  out  SLAVE_NUM×4
- s_read / s_write  out  SLAVE_NUM×1
- s_write_data  out  SLAVE_NUM×32
- s_begin_burst_transfer  out  SLAVE_NUM×1
- s_burst_count  out  SLAVE_NUM×8
- s_wait_request  in  SLAVE_NUM×1
- s_read_data  in  SLAVE_NUM×32
- s_read_data_valid  in  SLAVE_NUM×1
- decode_err  out  1  single-cycle pulse when an unmapped command is accepted

Behaviour:
- Decode: slave i matches when FIELD_LEN[i] != 0 and m_address[31:32-LEN] == BLOCK[31:32-LEN]. On multiple matches the lowest index wins. No match selects the error responder. Decode is combinational and adds zero cycles.
- Forwarding: address, byte_en, write_data and burst fields are broadcast to all slaves. read/write/begin_burst are driven only to the selected slave. m_wait_request = s_wait_request[sel] OR internal stall.
- A command is accepted when a strobe is high and m_wait_request=0.
- FSM states:
  - IDLE: forwards commands as decoded.
  - WR_BURST: entered on an accepted write with begin_burst and burst_count>1. The selected slave is locked and decode is ignored. A beat counter is loaded with burst_count-1 and decrements on each accepted write beat. Returns to IDLE when the counter reaches 0.
  - DRAIN: entered when a read or write targets a slave different from rd_sel while rd_beats>0. m_wait_request is held at 1 and the state returns to IDLE when rd_beats==0.
- Read tracking:
  - Accepted read: rd_beats += max(burst_count,1) and rd_sel is set to the target (slave or error responder).
  - Each returned beat decrements rd_beats.
  - Accept and return in the same cycle apply both updates.
  - Stall if rd_beats + new beats > MAX_RD_BEATS.
- Read return: m_read_data / m_read_data_valid are muxed from rd_sel. s_read_data_valid from any slave other than rd_sel is dropped.
- Error responder:
  - Accepts unmapped commands with no wait and pulses decode_err.
  - Writes are discarded.
  - Reads return max(burst_count,1) beats of ERR_RD_DATA, one per cycle, starting the cycle after acceptance.
- Reset values:
  - FSM = IDLE; rd_beats = 0; burst counter = 0; rd_sel = 0.
  - All s_read, s_write, s_begin_burst_transfer = 0.
  - m_read_data_valid = 0, decode_err = 0, m_read_data = 0.
- Reset mid-burst or with reads outstanding aborts all tracking. Late slave read data after reset is dropped because rd_beats = 0.

Decomposition:
- Extend package avl_bus_type with:
  - avl_rsp_t {read_data, read_data_valid, wait_request};
  - the AVL_BUS_ADDR_MAP_TAB_* default constants;
  - a function avl_addr_match(addr, len, block).
- One sub-module, avl_bus_err_slave, implements the error responder: beat counter plus decode_err pulse.

Test Plan:
- Single read to 0x8001_0004 with slave2 returning 0x1234_5678 one cycle later -> only s_read[2] asserted; m_read_data=0x1234_5678 with valid; rd_beats back to 0.
- Write burst of 4 at 0x8003_0000, address changed to 0x8005_0000 on beats 2-4 -> all 4 beats go to slave4; FSM returns to IDLE after beat 4.
- Read burst of 8 to slave1, then read to slave3 issued immediately -> m_wait_request=1 until the 8th slave1 beat returns, then slave3 read accepted.
- Read of 0x7FFF_FFF0 with entry0 FIELD_LEN set to 0 -> decode_err pulse, one beat of ERR_RD_DATA; no s_read asserted.
- Reads totalling 64 beats outstanding, then one more read -> stalled until a beat returns; an accept and return in the same cycle keeps rd_beats at 64.
- rst asserted in WR_BURST with 3 beats remaining -> all outputs at reset values immediately; the next command decodes normally.

Source files
------------

// File: rtl/avl_bus_type.sv
// Shared types, default address map and helpers for the Avalon-MM router.
package avl_bus_type;

    // Largest slave count the address-map tables can describe.
    localparam int AVL_BUS_MAX_SLAVES = 32;

    // Default map: entry 0 covers the lower half of the address space,
    // entries 1..7 each own one 64 KiB window starting at 0x8000_0000.
    localparam int AVL_BUS_ADDR_MAP_TAB_FIELD_LEN [0:31] = '{
        1, 16, 16, 16, 16, 16, 16, 16,
        0,  0,  0,  0,  0,  0,  0,  0,
        0,  0,  0,  0,  0,  0,  0,  0,
        0,  0,  0,  0,  0,  0,  0,  0
    };

    localparam int AVL_BUS_ADDR_MAP_TAB_ADDR_BLOCK [0:31] = '{
        32'h0000_0000, 32'h8000_0000, 32'h8001_0000, 32'h8002_0000,
        32'h8003_0000, 32'h8004_0000, 32'h8005_0000, 32'h8006_0000,
        0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 0, 0, 0, 0, 0, 0
    };

    // Response bundle of one target (slave or internal error responder).
    typedef struct packed {
        logic [31:0] read_data;
        logic        read_data_valid;
        logic        wait_request;
    } avl_rsp_t;

    // Router control states.
    typedef enum logic [1:0] {
        RTR_IDLE     = 2'd0,
        RTR_WR_BURST = 2'd1,
        RTR_DRAIN    = 2'd2
    } avl_rtr_state_e;

    // True when the upper 'len' bits of addr equal those of block.
    // A zero length disables the entry; lengths above 32 compare all bits.
    function automatic logic avl_addr_match(input logic [31:0] addr,
                                            input int          len,
                                            input int          block);
        logic [31:0] mask;
        int          n;
        if (len <= 0) begin
            return 1'b0;
        end
        n    = (len > 32) ? 32 : len;
        mask = 32'hFFFF_FFFF << (32 - n);
        return ((addr ^ 32'(block)) & mask) == 32'h0;
    endfunction

    // Number of beats a burst count stands for; zero means a single beat.
    function automatic logic [7:0] avl_burst_beats(input logic [7:0] count);
        return (count == 8'd0) ? 8'd1 : count;
    endfunction

endpackage

// File: rtl/avl_bus_err_slave.sv
// Internal responder for commands that hit no mapped slave: never stalls,
// drops writes, returns ERR_RD_DATA beats for reads and flags the access.
module avl_bus_err_slave
    import avl_bus_type::*;
#(
    parameter logic [31:0] ERR_RD_DATA = 32'h0000_0000,
    parameter int          CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rd_acc,
    input  logic       i_wr_acc,
    input  logic [7:0] i_beats,
    output avl_rsp_t   o_rsp,
    output logic       o_decode_err
);

    logic [CNT_W-1:0] r_beats_left;
    logic             r_decode_err;
    logic             w_valid;

    assign w_valid = (r_beats_left != '0);

    // Beat counter: one beat leaves per cycle, accepted reads add theirs;
    // beats therefore start the cycle after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beats_left <= '0;
        end else begin
            r_beats_left <= r_beats_left - CNT_W'(w_valid)
                          + (i_rd_acc ? CNT_W'(i_beats) : '0);
        end
    end

    // One-cycle error flag for every accepted unmapped command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decode_err <= 1'b0;
        end else begin
            r_decode_err <= i_rd_acc | i_wr_acc;
        end
    end

    assign o_rsp = '{read_data:       (w_valid ? ERR_RD_DATA : 32'h0),
                     read_data_valid: w_valid,
                     wait_request:    1'b0};
    assign o_decode_err = r_decode_err;

endmodule

// File: rtl/avl_bus_router.sv
// 1-master to N-slave Avalon-MM router: combinational address decode, write
// burst locking, in-order read return tracking and an unmapped-access
// responder.
module avl_bus_router
    import avl_bus_type::*;
#(
    parameter int          SLAVE_NUM                          = 8,
    parameter int          ADDR_MAP_TAB_FIELD_LEN  [0:31]     = AVL_BUS_ADDR_MAP_TAB_FIELD_LEN,
    parameter int          ADDR_MAP_TAB_ADDR_BLOCK [0:31]     = AVL_BUS_ADDR_MAP_TAB_ADDR_BLOCK,
    parameter int          MAX_RD_BEATS                       = 64,
    parameter logic [31:0] ERR_RD_DATA                        = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    // master side
    input  logic [31:0]                 m_address,
    input  logic [3:0]                  m_byte_en,
    input  logic                        m_read,
    input  logic                        m_write,
    input  logic [31:0]                 m_write_data,
    input  logic                        m_begin_burst_transfer,
    input  logic [7:0]                  m_burst_count,
    output logic                        m_wait_request,
    output logic [31:0]                 m_read_data,
    output logic                        m_read_data_valid,
    // slave side
    output logic [SLAVE_NUM-1:0][31:0]  s_address,
    output logic [SLAVE_NUM-1:0][3:0]   s_byte_en,
    output logic [SLAVE_NUM-1:0]        s_read,
    output logic [SLAVE_NUM-1:0]        s_write,
    output logic [SLAVE_NUM-1:0][31:0]  s_write_data,
    output logic [SLAVE_NUM-1:0]        s_begin_burst_transfer,
    output logic [SLAVE_NUM-1:0][7:0]   s_burst_count,
    input  logic [SLAVE_NUM-1:0]        s_wait_request,
    input  logic [SLAVE_NUM-1:0][31:0]  s_read_data,
    input  logic [SLAVE_NUM-1:0]        s_read_data_valid,
    output logic                        decode_err
);

    // Target index SLAVE_NUM is the internal error responder.
    localparam int SEL_W   = $clog2(SLAVE_NUM + 1);
    localparam int ERR_IDX = SLAVE_NUM;
    localparam int RB_W    = $clog2(MAX_RD_BEATS + 1);
    localparam int SUM_W   = RB_W + 9;

    avl_rtr_state_e   r_state;
    avl_rtr_state_e   w_state_next;
    logic [SEL_W-1:0] r_rd_sel;
    logic [SEL_W-1:0] r_burst_sel;
    logic [7:0]       r_burst_cnt;
    logic [RB_W-1:0]  r_rd_beats;

    logic [SEL_W-1:0] w_dec_sel;
    logic [SEL_W-1:0] w_sel;
    logic [7:0]       w_beats;
    logic             w_cmd;
    logic             w_ret;
    logic             w_conflict;
    logic             w_overflow;
    logic             w_stall;
    logic             w_tgt_wait;
    logic             w_acc;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_burst_start;
    logic             w_burst_last;
    logic [SUM_W-1:0] w_rd_need;
    logic [RB_W-1:0]  w_rd_beats_next;
    logic [SLAVE_NUM-1:0] w_hit;
    avl_rsp_t         w_rsp [0:SLAVE_NUM];

    // ------------------------------------------------------------------
    // Address decode: lowest matching index wins, no match -> error target
    // ------------------------------------------------------------------
    always_comb begin
        w_dec_sel = SEL_W'(ERR_IDX);
        for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
            if (avl_addr_match(m_address, ADDR_MAP_TAB_FIELD_LEN[i],
                               ADDR_MAP_TAB_ADDR_BLOCK[i])) begin
                w_dec_sel = SEL_W'(i);
            end
        end
    end

    // A write burst keeps its slave regardless of the addresses that follow.
    assign w_sel   = (r_state == RTR_WR_BURST) ? r_burst_sel : w_dec_sel;
    assign w_beats = avl_burst_beats(m_burst_count);
    assign w_cmd   = m_read | m_write;

    // A returned beat counts only from the target that owns the open reads.
    assign w_ret   = w_rsp[r_rd_sel].read_data_valid && (r_rd_beats != '0);

    // Outstanding beats if the present read were accepted this cycle.
    assign w_rd_need = SUM_W'(r_rd_beats) - SUM_W'(w_ret) + SUM_W'(w_beats);

    // FSM outputs: internal stall sources (also holds the master in reset).
    always_comb begin
        w_conflict = (r_state == RTR_IDLE) && w_cmd && (r_rd_beats != '0)
                  && (w_dec_sel != r_rd_sel);
        w_overflow = m_read && (w_rd_need > SUM_W'(MAX_RD_BEATS));
        w_stall    = rst || (r_state == RTR_DRAIN) || w_conflict || w_overflow;
    end

    assign w_tgt_wait     = w_rsp[w_sel].wait_request;
    assign m_wait_request = w_stall | w_tgt_wait;

    assign w_acc     = w_cmd & ~m_wait_request;
    assign w_rd_acc  = w_acc & m_read;
    assign w_wr_acc  = w_acc & m_write;
    assign w_burst_start = (r_state == RTR_IDLE) && w_wr_acc
                        && m_begin_burst_transfer && (m_burst_count > 8'd1);
    assign w_burst_last  = (r_state == RTR_WR_BURST) && w_wr_acc
                        && (r_burst_cnt <= 8'd1);

    assign w_rd_beats_next = r_rd_beats - RB_W'(w_ret)
                           + (w_rd_acc ? RB_W'(w_beats) : '0);

    // ------------------------------------------------------------------
    // Per-slave forwarding: data fields broadcast, strobes to the target
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < SLAVE_NUM; gi++) begin : g_slv
            assign w_hit[gi]                  = (w_sel == SEL_W'(gi)) && !w_stall;
            assign s_address[gi]              = m_address;
            assign s_byte_en[gi]              = m_byte_en;
            assign s_write_data[gi]           = m_write_data;
            assign s_burst_count[gi]          = m_burst_count;
            assign s_read[gi]                 = m_read  && w_hit[gi];
            assign s_write[gi]                = m_write && w_hit[gi];
            assign s_begin_burst_transfer[gi] = m_begin_burst_transfer && w_hit[gi];
            assign w_rsp[gi] = '{read_data:       s_read_data[gi],
                                 read_data_valid: s_read_data_valid[gi],
                                 wait_request:    s_wait_request[gi]};
        end
    endgenerate

    avl_bus_err_slave #(
        .ERR_RD_DATA (ERR_RD_DATA),
        .CNT_W       (SUM_W)
    ) u_err_slave (
        .clk          (clk),
        .rst          (rst),
        .i_rd_acc     (w_rd_acc && (w_sel == SEL_W'(ERR_IDX))),
        .i_wr_acc     (w_wr_acc && (w_sel == SEL_W'(ERR_IDX))),
        .i_beats      (w_beats),
        .o_rsp        (w_rsp[ERR_IDX]),
        .o_decode_err (decode_err)
    );

    // Read data path: muxed from the owner of the open reads, zero otherwise.
    assign m_read_data_valid = w_ret;
    assign m_read_data       = w_ret ? w_rsp[r_rd_sel].read_data : 32'h0;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RTR_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: lock on multi-beat write bursts, drain before
    // switching away from the target that still owes read beats.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RTR_IDLE: begin
                if (w_burst_start) begin
                    w_state_next = RTR_WR_BURST;
                end else if (w_conflict && (w_rd_beats_next != '0)) begin
                    w_state_next = RTR_DRAIN;
                end
            end
            RTR_WR_BURST: begin
                if (w_burst_last) begin
                    w_state_next = RTR_IDLE;
                end
            end
            RTR_DRAIN: begin
                if (w_rd_beats_next == '0) begin
                    w_state_next = RTR_IDLE;
                end
            end
            default: w_state_next = RTR_IDLE;
        endcase
    end

    // Write burst beat counter and locked target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_burst_cnt <= 8'd0;
            r_burst_sel <= '0;
        end else if (w_burst_start) begin
            r_burst_cnt <= m_burst_count - 8'd1;
            r_burst_sel <= w_sel;
        end else if ((r_state == RTR_WR_BURST) && w_wr_acc) begin
            r_burst_cnt <= r_burst_cnt - 8'd1;
        end
    end

    // Outstanding read beats and the target they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_beats <= '0;
            r_rd_sel   <= '0;
        end else begin
            r_rd_beats <= w_rd_beats_next;
            if (w_rd_acc) begin
                r_rd_sel <= w_sel;
            end
        end
    end

endmodule
